// File: rtl/scalar_rf_pkg.sv
// Shared types and constants for the scalar register file and its writeback path.
package scalar_rf_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 1 << ADDR_W;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    // One writeback request as presented by a pipeline stage.
    typedef struct packed {
        logic      valid;
        reg_addr_t rd;
        reg_data_t wd;
    } wb_req_t;

    // Identifies a writeback source; also the encoding of the round-robin pointer.
    typedef enum logic {
        SRC_EXEC = 1'b0,
        SRC_MEM  = 1'b1
    } wb_src_e;

    // Round-robin pick between two requesters. A lone requester always wins;
    // on a tie the source that did not win last time is chosen.
    function automatic logic [1:0] rr_grant(input logic v0, input logic v1,
                                            input wb_src_e last);
        logic [1:0] g;
        g = {v1, v0};
        if (v0 && v1) begin
            g = (last == SRC_MEM) ? 2'b01 : 2'b10;
        end
        return g;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per scalar register, set when decode
// issues a writer and cleared when the write reaches the register file.
module rf_scoreboard
    import scalar_rf_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_set_valid,
    input  logic [ADDR_W-1:0] i_set_addr,
    input  logic              i_clr_valid,
    input  logic [ADDR_W-1:0] i_clr_addr,
    input  logic [ADDR_W-1:0] i_rs [3],
    input  logic [ADDR_W-1:0] i_issue_rd,
    output logic [2:0]        o_hazard,
    output logic              o_issue_stall
);

    logic [NREGS-1:0] r_busy;

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_busy
            logic w_set;
            logic w_clr;
            assign w_set = i_set_valid && (i_set_addr == ADDR_W'(gi));
            assign w_clr = i_clr_valid && (i_clr_addr == ADDR_W'(gi));

            // Per-register busy bit: a new issue outranks a retiring write to
            // the same register, since the new writer is still outstanding.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_busy[gi] <= 1'b0;
                end else if (w_set) begin
                    r_busy[gi] <= 1'b1;
                end else if (w_clr) begin
                    r_busy[gi] <= 1'b0;
                end
            end
        end

        for (gi = 0; gi < 3; gi++) begin : g_hazard
            assign o_hazard[gi] = r_busy[i_rs[gi]];
        end
    endgenerate

    assign o_issue_stall = r_busy[i_issue_rd];

endmodule

// File: rtl/scalar_rf_wb_arbiter.sv
// Writeback arbiter for the scalar register file: round-robin between the
// execute and memory-load stages, one registered write per cycle, plus the
// pending-write scoreboard used by decode for hazard detection.
module scalar_rf_wb_arbiter
    import scalar_rf_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              src0_valid,
    input  logic [ADDR_W-1:0] src0_rd,
    input  logic [DATA_W-1:0] src0_wd,
    output logic              src0_ready,
    input  logic              src1_valid,
    input  logic [ADDR_W-1:0] src1_rd,
    input  logic [DATA_W-1:0] src1_wd,
    output logic              src1_ready,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic              issue_stall,
    input  logic [ADDR_W-1:0] RS1,
    input  logic [ADDR_W-1:0] RS2,
    input  logic [ADDR_W-1:0] RS3,
    output logic [2:0]        hazard,
    output logic [ADDR_W-1:0] RD,
    output logic [DATA_W-1:0] WD,
    output logic              WES
);

    wb_req_t           w_req [2];
    wb_req_t           w_sel;
    logic [1:0]        w_grant;
    logic              w_xfer;
    logic [ADDR_W-1:0] w_rs [3];

    wb_src_e           r_last;
    logic [ADDR_W-1:0] r_rd;
    logic [DATA_W-1:0] r_wd;
    logic              r_wes;

    assign w_req[0] = '{valid: src0_valid, rd: src0_rd, wd: src0_wd};
    assign w_req[1] = '{valid: src1_valid, rd: src1_rd, wd: src1_wd};

    // Nothing is accepted while reset is asserted.
    assign w_grant    = rst ? 2'b00 : rr_grant(w_req[0].valid, w_req[1].valid, r_last);
    assign src0_ready = w_grant[0];
    assign src1_ready = w_grant[1];
    assign w_xfer     = |w_grant;
    assign w_sel      = w_grant[1] ? w_req[1] : w_req[0];

    // Output register to the RF write port; the pointer advances only on a transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= SRC_MEM;
            r_rd   <= '0;
            r_wd   <= '0;
            r_wes  <= 1'b0;
        end else begin
            r_wes <= w_xfer;
            if (w_xfer) begin
                r_last <= w_grant[1] ? SRC_MEM : SRC_EXEC;
                r_rd   <= w_sel.rd;
                r_wd   <= w_sel.wd;
            end
        end
    end

    assign RD  = r_rd;
    assign WD  = r_wd;
    assign WES = r_wes;

    assign w_rs[0] = RS1;
    assign w_rs[1] = RS2;
    assign w_rs[2] = RS3;

    // The busy bit clears on the same edge that commits the write to the RF.
    rf_scoreboard u_scoreboard (
        .clk           (clk),
        .rst           (rst),
        .i_set_valid   (issue_valid),
        .i_set_addr    (issue_rd),
        .i_clr_valid   (r_wes),
        .i_clr_addr    (r_rd),
        .i_rs          (w_rs),
        .i_issue_rd    (issue_rd),
        .o_hazard      (hazard),
        .o_issue_stall (issue_stall)
    );

endmodule

// File: tb/tb_scalar_rf_wb_arbiter.sv
// Directed bench for scalar_rf_wb_arbiter. Expected RF writes go into a queue
// as stimulus is issued; a negedge monitor pops one entry per WES cycle.
module tb_scalar_rf_wb_arbiter;
    import scalar_rf_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              src0_valid, src1_valid;
    logic [ADDR_W-1:0] src0_rd, src1_rd;
    logic [DATA_W-1:0] src0_wd, src1_wd;
    logic              src0_ready, src1_ready;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_rd;
    logic              issue_stall;
    logic [ADDR_W-1:0] RS1, RS2, RS3;
    logic [2:0]        hazard;
    logic [ADDR_W-1:0] RD;
    logic [DATA_W-1:0] WD;
    logic              WES;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] wd;
    } exp_t;
    exp_t exp_q [$];

    always #5 clk = ~clk;

    scalar_rf_wb_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .src0_valid  (src0_valid),
        .src0_rd     (src0_rd),
        .src0_wd     (src0_wd),
        .src0_ready  (src0_ready),
        .src1_valid  (src1_valid),
        .src1_rd     (src1_rd),
        .src1_wd     (src1_wd),
        .src1_ready  (src1_ready),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_stall (issue_stall),
        .RS1         (RS1),
        .RS2         (RS2),
        .RS3         (RS3),
        .hazard      (hazard),
        .RD          (RD),
        .WD          (WD),
        .WES         (WES)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic drive0(input wb_req_t r);
        src0_valid = r.valid;
        src0_rd    = r.rd;
        src0_wd    = r.wd;
    endtask

    task automatic drive1(input wb_req_t r);
        src1_valid = r.valid;
        src1_rd    = r.rd;
        src1_wd    = r.wd;
    endtask

    task automatic expect_wb(input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] wd);
        exp_t e;
        e.rd = rd;
        e.wd = wd;
        exp_q.push_back(e);
    endtask

    // Monitor: every cycle with WES high must match the oldest expected write.
    always @(negedge clk) begin
        exp_t e;
        if (WES === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected actual RD=%0d WD=%h required no write", RD, WD);
            end else begin
                e = exp_q.pop_front();
                if (RD !== e.rd || WD !== e.wd) begin
                    errors++;
                    $display("FAIL wb_data actual RD=%0d WD=%h required RD=%0d WD=%h",
                             RD, WD, e.rd, e.wd);
                end else begin
                    $display("wb   RD=%0d WD=%h", RD, WD);
                end
            end
        end
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        rst = 1'b1;
        drive0('{valid: 1'b1, rd: 5'd9,  wd: 16'h1111});
        drive1('{valid: 1'b1, rd: 5'd10, wd: 16'h2222});
        issue_valid = 1'b0;
        issue_rd    = '0;
        RS1 = '0; RS2 = '0; RS3 = '0;

        // Reset held two cycles with both sources requesting.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            chk("rst_ready", {30'd0, src1_ready, src0_ready}, 32'd0);
            chk("rst_wes", WES, 32'd0);
            chk("rst_hazard", hazard, 32'd0);
        end
        chk("rst_rd", RD, 32'd0);
        chk("rst_wd", WD, 32'd0);
        chk("rst_stall", issue_stall, 32'd0);

        // First tie after reset goes to src0.
        @(negedge clk); rst = 1'b0; #1;
        chk("first_tie", {30'd0, src1_ready, src0_ready}, 32'd1);
        expect_wb(5'd9, 16'h1111);
        @(negedge clk); drive0('{valid: 1'b0, rd: 5'd0, wd: 16'h0}); #1;
        chk("lone_src1", {30'd0, src1_ready, src0_ready}, 32'd2);
        expect_wb(5'd10, 16'h2222);
        @(negedge clk); drive1('{valid: 1'b0, rd: 5'd0, wd: 16'h0}); #1;

        // Contention: both valid, each holds data until accepted.
        @(negedge clk);
        drive0('{valid: 1'b1, rd: 5'd2, wd: 16'hA001});
        drive1('{valid: 1'b1, rd: 5'd5, wd: 16'hB001}); #1;
        chk("cont_g0", {30'd0, src1_ready, src0_ready}, 32'd1);
        expect_wb(5'd2, 16'hA001);
        @(negedge clk); drive0('{valid: 1'b1, rd: 5'd2, wd: 16'hA002}); #1;
        chk("cont_g1", {30'd0, src1_ready, src0_ready}, 32'd2);
        expect_wb(5'd5, 16'hB001);
        @(negedge clk); drive1('{valid: 1'b1, rd: 5'd5, wd: 16'hB002}); #1;
        chk("cont_g2", {30'd0, src1_ready, src0_ready}, 32'd1);
        expect_wb(5'd2, 16'hA002);
        @(negedge clk); drive0('{valid: 1'b1, rd: 5'd2, wd: 16'hA003}); #1;
        chk("cont_g3", {30'd0, src1_ready, src0_ready}, 32'd2);
        expect_wb(5'd5, 16'hB002);
        @(negedge clk); drive1('{valid: 1'b0, rd: 5'd0, wd: 16'h0}); #1;
        chk("cont_g4", {30'd0, src1_ready, src0_ready}, 32'd1);
        expect_wb(5'd2, 16'hA003);
        chk("cont_wes_run", WES, 32'd1);

        // Single write from src0.
        @(negedge clk); drive0('{valid: 1'b1, rd: 5'd7, wd: 16'hCCDD}); #1;
        chk("single_ready", {30'd0, src1_ready, src0_ready}, 32'd1);
        expect_wb(5'd7, 16'hCCDD);
        @(negedge clk); drive0('{valid: 1'b0, rd: 5'd0, wd: 16'h0}); #1;
        chk("single_rd", RD, 32'd7);
        chk("single_wd", WD, 32'hCCDD);
        @(negedge clk); #1;
        chk("idle_wes", WES, 32'd0);

        // Scoreboard: issue r3, then src1 retires it.
        @(negedge clk);
        issue_valid = 1'b1; issue_rd = 5'd3;
        RS1 = 5'd3; RS2 = 5'd4; RS3 = 5'd3; #1;
        chk("sb_pre_stall", issue_stall, 32'd0);
        chk("sb_pre_hazard", hazard, 32'd0);
        @(negedge clk); issue_valid = 1'b0; #1;
        chk("sb_hazard_set", hazard, 32'h5);
        chk("sb_waw_stall", issue_stall, 32'd1);
        @(negedge clk); drive1('{valid: 1'b1, rd: 5'd3, wd: 16'h3333}); #1;
        chk("sb_wr_ready", {30'd0, src1_ready, src0_ready}, 32'd2);
        chk("sb_hazard_n", hazard, 32'h5);
        expect_wb(5'd3, 16'h3333);
        @(negedge clk); drive1('{valid: 1'b0, rd: 5'd0, wd: 16'h0}); #1;
        chk("sb_hazard_n1", hazard, 32'h5);
        @(negedge clk); #1;
        chk("sb_hazard_n2", hazard, 32'd0);
        chk("sb_stall_clr", issue_stall, 32'd0);

        // Set/clear collision on r1: set wins.
        @(negedge clk);
        drive0('{valid: 1'b1, rd: 5'd1, wd: 16'h0101});
        RS1 = 5'd1; RS2 = 5'd0; RS3 = 5'd0; #1;
        chk("col_ready", {30'd0, src1_ready, src0_ready}, 32'd1);
        expect_wb(5'd1, 16'h0101);
        @(negedge clk);
        drive0('{valid: 1'b0, rd: 5'd0, wd: 16'h0});
        issue_valid = 1'b1; issue_rd = 5'd1; #1;
        chk("col_stall", issue_stall, 32'd0);
        @(negedge clk);
        issue_valid = 1'b0;
        drive1('{valid: 1'b1, rd: 5'd1, wd: 16'h0111}); #1;
        chk("col_set_wins", hazard, 32'd1);
        expect_wb(5'd1, 16'h0111);
        // Clear r1 and set r8 on the same edge: both apply.
        @(negedge clk);
        drive1('{valid: 1'b0, rd: 5'd0, wd: 16'h0});
        issue_valid = 1'b1; issue_rd = 5'd8; #1;
        chk("dual_pre", hazard, 32'd1);
        @(negedge clk);
        issue_valid = 1'b0; RS2 = 5'd8; #1;
        chk("dual_both", hazard, 32'h2);

        // Reset in the cycle WES is high.
        @(negedge clk);
        drive0('{valid: 1'b1, rd: 5'd8, wd: 16'h0808});
        issue_valid = 1'b1; issue_rd = 5'd12; #1;
        chk("mid_ready", {30'd0, src1_ready, src0_ready}, 32'd1);
        expect_wb(5'd8, 16'h0808);
        @(negedge clk);
        rst = 1'b1;
        drive0('{valid: 1'b0, rd: 5'd0, wd: 16'h0});
        drive1('{valid: 1'b1, rd: 5'd9, wd: 16'h9999});
        issue_rd = 5'd13;
        RS1 = 5'd12; RS2 = 5'd8; RS3 = 5'd13; #1;
        chk("mid_rst_ready", {30'd0, src1_ready, src0_ready}, 32'd0);
        chk("mid_pre_hazard", hazard, 32'h3);
        @(negedge clk);
        rst = 1'b0; issue_valid = 1'b0; issue_rd = 5'd12;
        drive0('{valid: 1'b1, rd: 5'd4, wd: 16'h4444}); #1;
        chk("mid_wes", WES, 32'd0);
        chk("mid_hazard", hazard, 32'd0);
        chk("mid_stall", issue_stall, 32'd0);
        chk("mid_last", {30'd0, src1_ready, src0_ready}, 32'd1);
        expect_wb(5'd4, 16'h4444);
        @(negedge clk); drive0('{valid: 1'b0, rd: 5'd0, wd: 16'h0}); #1;
        chk("post_src1", {30'd0, src1_ready, src0_ready}, 32'd2);
        expect_wb(5'd9, 16'h9999);
        @(negedge clk); drive1('{valid: 1'b0, rd: 5'd0, wd: 16'h0});

        repeat (3) @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
